// File: rtl/jam_search_param.sv
// Exhaustive N x N job-assignment search: walks every worker-to-job permutation in
// lexicographic order against a registered cost ROM, keeping the minimum, its count and first winner.
module jam_search_param #(
  parameter int N     = 8,
  parameter int IDXW  = 3,
  parameter int COSTW = 7,
  parameter int SUMW  = 10,
  parameter int CNTW  = 16,
  parameter int PRUNE = 0
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              START,
  output logic              BUSY,
  output logic              REQ,
  output logic [IDXW-1:0]   W,
  output logic [IDXW-1:0]   J,
  input  logic [COSTW-1:0]  Cost,
  output logic [SUMW-1:0]   MinCost,
  output logic [CNTW-1:0]   MatchCount,
  output logic [N*IDXW-1:0] BestSeq,
  output logic              Valid
);

  localparam int CW = IDXW + 1;

  typedef enum logic [2:0] {IDLE, FETCH, EVAL, NEXT, DONE} state_t;
  typedef logic [IDXW-1:0] idx_t;

  state_t            state_reg, state_next;
  logic [CW-1:0]     cnt_reg, cnt_next;
  logic [SUMW-1:0]   sum_reg, sum_next;
  logic [SUMW-1:0]   min_reg, min_next;
  logic [CNTW-1:0]   match_reg, match_next;
  logic [N*IDXW-1:0] best_reg, best_next;
  logic              busy_reg, busy_next;
  logic              valid_reg, valid_next;
  idx_t              w_hold_reg, j_hold_reg;
  idx_t              perm_reg [N];
  idx_t              perm_next [N];
  idx_t              perm_swap [N];
  idx_t              perm_succ [N];
  logic [N*IDXW-1:0] perm_packed;
  idx_t              j_sel;
  logic              req_c;
  idx_t              w_c, j_c;
  logic              prune_hit;
  logic              has_pivot;
  int                piv, succ;

  function automatic logic [N*IDXW-1:0] ident_seq();
    logic [N*IDXW-1:0] s;
    s = '0;
    for (int i = 0; i < N; i++) s[i*IDXW +: IDXW] = idx_t'(i);
    return s;
  endfunction

  // Lexicographic successor: rightmost ascent is the pivot; since the tail after it is
  // descending, the rightmost larger element is also the smallest larger one.
  always_comb begin
    has_pivot = 1'b0;
    piv       = 0;
    succ      = 0;
    for (int i = 0; i < N - 1; i++) begin
      if (perm_reg[i] < perm_reg[i+1]) begin
        has_pivot = 1'b1;
        piv       = i;
      end
    end
    for (int i = 0; i < N; i++) begin
      if (i > piv && perm_reg[i] > perm_reg[piv]) succ = i;
    end
    for (int i = 0; i < N; i++) begin
      perm_swap[i] = (i == piv) ? perm_reg[succ] : (i == succ) ? perm_reg[piv] : perm_reg[i];
    end
    for (int i = 0; i < N; i++) begin
      perm_succ[i] = (i > piv) ? perm_swap[N + piv - i] : perm_swap[i];
    end
  end

  always_comb begin
    perm_packed = '0;
    j_sel       = '0;
    for (int i = 0; i < N; i++) begin
      perm_packed[i*IDXW +: IDXW] = perm_reg[i];
      if (cnt_reg == CW'(i)) j_sel = perm_reg[i];
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    sum_next   = sum_reg;
    min_next   = min_reg;
    match_next = match_reg;
    best_next  = best_reg;
    busy_next  = busy_reg;
    valid_next = valid_reg;
    perm_next  = perm_reg;
    req_c      = 1'b0;
    w_c        = w_hold_reg;
    j_c        = j_hold_reg;
    prune_hit  = (PRUNE != 0) && (sum_reg > min_reg);

    unique case (state_reg)
      IDLE, DONE: begin
        if (START) begin
          min_next   = '1;
          match_next = '0;
          sum_next   = '0;
          cnt_next   = '0;
          valid_next = 1'b0;
          busy_next  = 1'b1;
          for (int i = 0; i < N; i++) perm_next[i] = idx_t'(i);
          state_next = FETCH;
        end
      end
      FETCH: begin
        if (prune_hit) begin
          state_next = NEXT;
        end else begin
          if (cnt_reg < CW'(N)) begin
            req_c = 1'b1;
            w_c   = cnt_reg[IDXW-1:0];
            j_c   = j_sel;
          end
          // Cost lags the address by one cycle, so cycle 0 has nothing to add yet.
          if (cnt_reg != '0) sum_next = sum_reg + SUMW'(Cost);
          if (cnt_reg == CW'(N)) state_next = EVAL;
          else                   cnt_next   = cnt_reg + 1'b1;
        end
      end
      EVAL: begin
        if (sum_reg < min_reg) begin
          min_next   = sum_reg;
          match_next = CNTW'(1);
          best_next  = perm_packed;
        end else if (sum_reg == min_reg && match_reg != '1) begin
          match_next = match_reg + 1'b1;
        end
        state_next = NEXT;
      end
      NEXT: begin
        sum_next = '0;
        cnt_next = '0;
        if (has_pivot) begin
          perm_next  = perm_succ;
          state_next = FETCH;
        end else begin
          busy_next  = 1'b0;
          valid_next = 1'b1;
          state_next = DONE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_reg  <= IDLE;
      cnt_reg    <= '0;
      sum_reg    <= '0;
      min_reg    <= '1;
      match_reg  <= '0;
      best_reg   <= ident_seq();
      busy_reg   <= 1'b0;
      valid_reg  <= 1'b0;
      w_hold_reg <= '0;
      j_hold_reg <= '0;
      for (int i = 0; i < N; i++) perm_reg[i] <= idx_t'(i);
    end else begin
      state_reg  <= state_next;
      cnt_reg    <= cnt_next;
      sum_reg    <= sum_next;
      min_reg    <= min_next;
      match_reg  <= match_next;
      best_reg   <= best_next;
      busy_reg   <= busy_next;
      valid_reg  <= valid_next;
      w_hold_reg <= w_c;
      j_hold_reg <= j_c;
      perm_reg   <= perm_next;
    end
  end

  assign BUSY       = busy_reg;
  assign REQ        = req_c;
  assign W          = w_c;
  assign J          = j_c;
  assign MinCost    = min_reg;
  assign MatchCount = match_reg;
  assign BestSeq    = best_reg;
  assign Valid      = valid_reg;

endmodule

// File: tb/tb_jam_search_param.sv
`timescale 1ns/1ps
// Three solver instances (N=3; N=4 with and without pruning) share clock, reset and START;
// a brute-force enumeration predicts results and exact cycle counts into per-instance queues.
module tb_jam_search_param;

  typedef struct packed {
    logic [9:0]  min;
    logic [15:0] cnt;
    logic [7:0]  best;
    logic [31:0] cyc;
  } exp_t;

  localparam int LIMIT = 2000;

  logic CLK = 1'b0;
  logic RST_N, START;
  always #5 CLK = ~CLK;

  logic       busy_a, req_a, valid_a, busy_p0, req_p0, valid_p0, busy_p1, req_p1, valid_p1;
  logic [1:0] w_a, j_a, w_p0, j_p0, w_p1, j_p1;
  logic [6:0] cost_a = '0, cost_p0 = '0, cost_p1 = '0;
  logic [9:0] min_a, min_p0, min_p1;
  logic [15:0] cnt_a;
  logic [2:0] cnt_p0, cnt_p1;
  logic [5:0] best_a;
  logic [7:0] best_p0, best_p1;

  logic [6:0] mat_a [4][4];
  logic [6:0] mat_b [4][4];
  logic [6:0] sm [3][3] = '{'{7'd4, 7'd2, 7'd8}, '{7'd4, 7'd3, 7'd7}, '{7'd3, 7'd1, 7'd6}};

  exp_t q_a[$], q_p0[$], q_p1[$];
  int checks = 0;
  int failures = 0;

  jam_search_param #(.N(3), .IDXW(2), .COSTW(7), .SUMW(10), .CNTW(16), .PRUNE(0)) dut_a (
    .CLK(CLK), .RST_N(RST_N), .START(START), .BUSY(busy_a), .REQ(req_a), .W(w_a), .J(j_a),
    .Cost(cost_a), .MinCost(min_a), .MatchCount(cnt_a), .BestSeq(best_a), .Valid(valid_a));

  jam_search_param #(.N(4), .IDXW(2), .COSTW(7), .SUMW(10), .CNTW(3), .PRUNE(0)) dut_p0 (
    .CLK(CLK), .RST_N(RST_N), .START(START), .BUSY(busy_p0), .REQ(req_p0), .W(w_p0), .J(j_p0),
    .Cost(cost_p0), .MinCost(min_p0), .MatchCount(cnt_p0), .BestSeq(best_p0), .Valid(valid_p0));

  jam_search_param #(.N(4), .IDXW(2), .COSTW(7), .SUMW(10), .CNTW(3), .PRUNE(1)) dut_p1 (
    .CLK(CLK), .RST_N(RST_N), .START(START), .BUSY(busy_p1), .REQ(req_p1), .W(w_p1), .J(j_p1),
    .Cost(cost_p1), .MinCost(min_p1), .MatchCount(cnt_p1), .BestSeq(best_p1), .Valid(valid_p1));

  // Registered cost ROMs: data for the address seen at an edge appears after that edge.
  always @(posedge CLK) begin
    cost_a  <= mat_a[w_a][j_a];
    cost_p0 <= mat_b[w_p0][j_p0];
    cost_p1 <= mat_b[w_p1][j_p1];
  end

  task automatic fill(input int mode);
    for (int w = 0; w < 4; w++) begin
      for (int j = 0; j < 4; j++) begin
        case (mode)
          0: begin mat_a[w][j] = 7'd5; mat_b[w][j] = 7'd5; end
          1: begin
            mat_a[w][j] = (w == j) ? 7'd0 : 7'd100;
            mat_b[w][j] = (w == j) ? 7'd0 : 7'd100;
          end
          2: begin
            mat_a[w][j] = (j == 2 - w) ? 7'd1 : 7'd50;
            mat_b[w][j] = (j == 3 - w) ? 7'd1 : 7'd50;
          end
          default: begin
            mat_a[w][j] = 7'd0;
            if (w < 3 && j < 3) mat_a[w][j] = sm[w][j];
            mat_b[w][j] = 7'($urandom_range(0, 30));
          end
        endcase
      end
    end
  endtask

  // Enumerates n^n digit strings (worker 0 most significant), keeps those that are
  // permutations, and replays the pruning rule to predict each permutation's cycle cost.
  function automatic exp_t model(input int n, input int prune, input int cmax,
                                 input logic [6:0] m [4][4]);
    exp_t e;
    int d [4];
    int mn, cnt, cyc, total, prefix, cut, r, pw;
    bit ok;
    e = '0; mn = 1023; cnt = 0; cyc = 0; pw = 1;
    for (int w = 0; w < n; w++) begin
      e.best[w*2 +: 2] = 2'(w);
      pw = pw * n;
    end
    for (int code = 0; code < pw; code++) begin
      r = code; ok = 1'b1;
      for (int w = n - 1; w >= 0; w--) begin d[w] = r % n; r = r / n; end
      for (int a = 0; a < n; a++)
        for (int b = 0; b < a; b++)
          if (d[a] == d[b]) ok = 1'b0;
      if (ok) begin
        total = 0; prefix = 0; cut = -1;
        for (int w = 0; w < n; w++) total += int'(m[w][d[w]]);
        for (int c = 0; c <= n; c++) begin
          if (c >= 2) prefix += int'(m[c-2][d[c-2]]);
          if (prune != 0 && cut < 0 && prefix > mn) cut = c;
        end
        if (cut >= 0) begin
          cyc += cut + 2;
        end else begin
          cyc += n + 3;
          if (total < mn) begin
            mn = total; cnt = 1;
            for (int w = 0; w < n; w++) e.best[w*2 +: 2] = 2'(d[w]);
          end else if (total == mn && cnt < cmax) begin
            cnt++;
          end
        end
      end
    end
    e.min = 10'(mn); e.cnt = 16'(cnt); e.cyc = 32'(cyc);
    return e;
  endfunction

  function automatic string fmt(input exp_t e);
    return $sformatf("min=%0d cnt=%0d best=%h cyc=%0d", e.min, e.cnt, e.best, $signed(e.cyc));
  endfunction

  task automatic push_expected();
    q_a.push_back(model(3, 0, 65535, mat_a));
    q_p0.push_back(model(4, 0, 7, mat_b));
    q_p1.push_back(model(4, 1, 7, mat_b));
  endtask

  task automatic run_job(input bit poke, output exp_t ra, output exp_t r0, output exp_t r1,
                         output logic [2:0] v_after, output logic [2:0] b_after);
    exp_t la, l0, l1;
    la = '0; l0 = '0; l1 = '0;
    @(negedge CLK); START = 1'b1;
    @(posedge CLK); #1; START = 1'b0;
    v_after = {valid_a, valid_p0, valid_p1};
    b_after = {busy_a, busy_p0, busy_p1};
    fork
      begin
        int t = 0;
        while (t < LIMIT && !valid_a) begin @(posedge CLK); #1; t++; end
        la.min = min_a; la.cnt = 16'(cnt_a); la.best = 8'(best_a);
        la.cyc = valid_a ? 32'(t) : 32'hFFFF_FFFF;
      end
      begin
        int t = 0;
        while (t < LIMIT && !valid_p0) begin @(posedge CLK); #1; t++; end
        l0.min = min_p0; l0.cnt = 16'(cnt_p0); l0.best = best_p0;
        l0.cyc = valid_p0 ? 32'(t) : 32'hFFFF_FFFF;
      end
      begin
        int t = 0;
        while (t < LIMIT && !valid_p1) begin @(posedge CLK); #1; t++; end
        l1.min = min_p1; l1.cnt = 16'(cnt_p1); l1.best = best_p1;
        l1.cyc = valid_p1 ? 32'(t) : 32'hFFFF_FFFF;
      end
      begin
        if (poke) begin
          repeat (4) @(negedge CLK);
          START = 1'b1;
          @(negedge CLK);
          START = 1'b0;
        end
      end
    join
    ra = la; r0 = l0; r1 = l1;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge CLK);
    #1;
    checks++;
    if ({req_a, busy_a, valid_a, w_a, j_a, min_a, cnt_a, best_a} !== {3'b000, 4'd0, 10'h3FF, 16'd0, 6'h24}) begin
      failures++;
      $display("FAIL reset_a got %h want %h", {req_a, busy_a, valid_a, w_a, j_a, min_a, cnt_a, best_a},
               {3'b000, 4'd0, 10'h3FF, 16'd0, 6'h24});
    end
    checks++;
    if ({req_p0, busy_p0, valid_p0, w_p0, j_p0, min_p0, cnt_p0, best_p0} !== {3'b000, 4'd0, 10'h3FF, 3'd0, 8'hE4}) begin
      failures++;
      $display("FAIL reset_p0 got %h want %h", {req_p0, busy_p0, valid_p0, w_p0, j_p0, min_p0, cnt_p0, best_p0},
               {3'b000, 4'd0, 10'h3FF, 3'd0, 8'hE4});
    end
    checks++;
    if ({req_p1, busy_p1, valid_p1, w_p1, j_p1, min_p1, cnt_p1, best_p1} !== {3'b000, 4'd0, 10'h3FF, 3'd0, 8'hE4}) begin
      failures++;
      $display("FAIL reset_p1 got %h want %h", {req_p1, busy_p1, valid_p1, w_p1, j_p1, min_p1, cnt_p1, best_p1},
               {3'b000, 4'd0, 10'h3FF, 3'd0, 8'hE4});
    end
    @(negedge CLK);
    RST_N = 1'b1;
  endtask

  task automatic test_const_saturate();
    exp_t ra, r0, r1, ea, e0, e1;
    logic [2:0] v, b;
    fill(0);
    push_expected();
    run_job(1'b0, ra, r0, r1, v, b);
    ea = q_a.pop_front(); e0 = q_p0.pop_front(); e1 = q_p1.pop_front();
    checks++; if (b !== 3'b111) begin failures++; $display("FAIL const_busy got %b want 111", b); end
    checks++; if (ra !== ea) begin failures++; $display("FAIL const_a got %s want %s", fmt(ra), fmt(ea)); end
    checks++; if (r0 !== e0) begin failures++; $display("FAIL const_sat_p0 got %s want %s", fmt(r0), fmt(e0)); end
    checks++; if (r1 !== e1) begin failures++; $display("FAIL const_sat_p1 got %s want %s", fmt(r1), fmt(e1)); end
  endtask

  task automatic test_diag_prune();
    exp_t ra, r0, r1, ea, e0, e1;
    logic [2:0] v, b;
    fill(1);
    push_expected();
    run_job(1'b0, ra, r0, r1, v, b);
    ea = q_a.pop_front(); e0 = q_p0.pop_front(); e1 = q_p1.pop_front();
    checks++; if (ra !== ea) begin failures++; $display("FAIL diag_a got %s want %s", fmt(ra), fmt(ea)); end
    checks++; if (r0 !== e0) begin failures++; $display("FAIL diag_p0 got %s want %s", fmt(r0), fmt(e0)); end
    checks++; if (r1 !== e1) begin failures++; $display("FAIL diag_p1 got %s want %s", fmt(r1), fmt(e1)); end
    checks++;
    if (!(r1.cyc < r0.cyc)) begin
      failures++;
      $display("FAIL prune_earlier got pruned=%0d want below %0d", r1.cyc, r0.cyc);
    end
  endtask

  task automatic test_antidiag();
    exp_t ra, r0, r1, ea, e0, e1;
    logic [2:0] v, b;
    fill(2);
    push_expected();
    run_job(1'b0, ra, r0, r1, v, b);
    ea = q_a.pop_front(); e0 = q_p0.pop_front(); e1 = q_p1.pop_front();
    checks++; if (ra !== ea) begin failures++; $display("FAIL anti_a got %s want %s", fmt(ra), fmt(ea)); end
    checks++; if (r0 !== e0) begin failures++; $display("FAIL anti_p0 got %s want %s", fmt(r0), fmt(e0)); end
    checks++; if (r1 !== e1) begin failures++; $display("FAIL anti_p1 got %s want %s", fmt(r1), fmt(e1)); end
  endtask

  task automatic test_matrix_start_ignored();
    exp_t ra, r0, r1, ea, e0, e1;
    logic [2:0] v, b;
    fill(3);
    push_expected();
    run_job(1'b1, ra, r0, r1, v, b);
    ea = q_a.pop_front(); e0 = q_p0.pop_front(); e1 = q_p1.pop_front();
    checks++; if (ra !== ea) begin failures++; $display("FAIL matrix_a got %s want %s", fmt(ra), fmt(ea)); end
    checks++; if (r0 !== e0) begin failures++; $display("FAIL matrix_p0 got %s want %s", fmt(r0), fmt(e0)); end
    checks++; if (r1 !== e1) begin failures++; $display("FAIL matrix_p1 got %s want %s", fmt(r1), fmt(e1)); end
  endtask

  task automatic test_reset_mid();
    exp_t ra, r0, r1, ea, e0, e1;
    logic [2:0] v, b;
    @(negedge CLK); START = 1'b1;
    @(posedge CLK); #1; START = 1'b0;
    repeat (8) @(posedge CLK);
    #2;
    checks++;
    if (req_a !== 1'b1 || busy_a !== 1'b1) begin
      failures++;
      $display("FAIL pre_reset got req=%b busy=%b want req=1 busy=1", req_a, busy_a);
    end
    RST_N = 1'b0;
    #1;
    checks++;
    if ({req_a, busy_a, valid_a, min_a, cnt_a, best_a} !== {3'b000, 10'h3FF, 16'd0, 6'h24}) begin
      failures++;
      $display("FAIL midrst_a got %h want %h", {req_a, busy_a, valid_a, min_a, cnt_a, best_a},
               {3'b000, 10'h3FF, 16'd0, 6'h24});
    end
    checks++;
    if ({req_p0, busy_p0, valid_p0, min_p0, cnt_p0} !== {3'b000, 10'h3FF, 3'd0}) begin
      failures++;
      $display("FAIL midrst_p0 got %h want %h", {req_p0, busy_p0, valid_p0, min_p0, cnt_p0}, {3'b000, 10'h3FF, 3'd0});
    end
    checks++;
    if ({req_p1, busy_p1, valid_p1, min_p1, cnt_p1} !== {3'b000, 10'h3FF, 3'd0}) begin
      failures++;
      $display("FAIL midrst_p1 got %h want %h", {req_p1, busy_p1, valid_p1, min_p1, cnt_p1}, {3'b000, 10'h3FF, 3'd0});
    end
    @(negedge CLK);
    RST_N = 1'b1;
    push_expected();
    run_job(1'b0, ra, r0, r1, v, b);
    ea = q_a.pop_front(); e0 = q_p0.pop_front(); e1 = q_p1.pop_front();
    checks++; if (ra !== ea) begin failures++; $display("FAIL after_rst_a got %s want %s", fmt(ra), fmt(ea)); end
    checks++; if (r0 !== e0) begin failures++; $display("FAIL after_rst_p0 got %s want %s", fmt(r0), fmt(e0)); end
    checks++; if (r1 !== e1) begin failures++; $display("FAIL after_rst_p1 got %s want %s", fmt(r1), fmt(e1)); end
  endtask

  task automatic test_back_to_back();
    exp_t ra, r0, r1, ea, e0, e1;
    logic [2:0] v, b;
    fill(1);
    push_expected();
    run_job(1'b0, ra, r0, r1, v, b);
    ea = q_a.pop_front(); e0 = q_p0.pop_front(); e1 = q_p1.pop_front();
    checks++; if (v !== 3'b000) begin failures++; $display("FAIL b2b_valid_clear got %b want 000", v); end
    checks++; if (b !== 3'b111) begin failures++; $display("FAIL b2b_busy got %b want 111", b); end
    checks++; if (ra !== ea) begin failures++; $display("FAIL b2b_a got %s want %s", fmt(ra), fmt(ea)); end
    checks++; if (r0 !== e0) begin failures++; $display("FAIL b2b_p0 got %s want %s", fmt(r0), fmt(e0)); end
    checks++; if (r1 !== e1) begin failures++; $display("FAIL b2b_p1 got %s want %s", fmt(r1), fmt(e1)); end
  endtask

  initial begin
    RST_N = 1'b0;
    START = 1'b0;
    fill(0);
    test_reset();
    test_const_saturate();
    test_diag_prune();
    test_antidiag();
    test_matrix_start_ignored();
    test_reset_mid();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
